serial_addsub: RTL
==================

// Module: serial_addsub
// PURPOSE
//  Parametrised digit-serial adder/subtractor. Operands are latched on a start request and
//  processed DIGIT bits per clock, LSB first, through a chain of full-adder/full-subtractor
//  cells with a registered carry/borrow between digits. It is used where a wide parallel
//  adder is too costly; result, carry/borrow and signed overflow are presented with a done pulse.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
//  DIGIT  1  bits processed per clock; must divide WIDTH exactly (1..WIDTH)
// PORTS
//  clk    in   1      clock; all state updates on rising edge
//  rst_n  in   1      reset, synchronous, active-low
//  start  in   1      request; accepted only in IDLE or DONE state
//  mode   in   1      0 = add (a+b+cin), 1 = subtract (a-b-cin)
//  a      in   WIDTH  operand A (unsigned or two's complement)
//  b      in   WIDTH  operand B
//  cin    in   1      carry-in (add) / borrow-in (subtract)
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse: res/cy/ovf updated this cycle
//  res    out  WIDTH  sum or difference
//  cy     out  1      carry-out (add) / borrow-out (subtract)
//  ovf    out  1      signed overflow
// BEHAVIOUR
//  - Reset (rst_n low at an edge): state=IDLE; busy=0, done=0, res=0, cy=0, ovf=0; any
//    operation in progress is abandoned and produces no done pulse. Reset overrides start.
//  - States: IDLE -> RUN (start=1) ; RUN -> RUN (cnt<N-1) ; RUN -> DONE (cnt==N-1) ;
//    DONE -> RUN (start=1) else IDLE. N = WIDTH/DIGIT.
//  - On acceptance: a, b, mode, cin are latched into internal shift regs; cnt=0; carry reg=cin.
//    Port inputs are don't-care while busy=1. start while busy=1 is ignored (not queued).
//  - Each RUN cycle: DIGIT LSBs of a/b pass through a DIGIT-long cell chain:
//      add: s=a^b^c, c'=(a&b)|(b&c)|(c&a)
//      sub: d=a^b^c, c'=(~(a^b)&c)|(~a&b)
//    Result digit shifts into an internal result reg from the MSB end; operand regs shift right
//    by DIGIT; chain carry-out is registered for the next digit.
//  - Latency: start sampled at edge of cycle 0 -> busy=1 in cycles 1..N -> done=1 in cycle N+1.
//  - res/cy/ovf are output registers loaded only on entry to DONE; held stable until the next
//    DONE (never show partial results).
//  - ovf (using latched a/b MSBs and final res MSB): add: a[W-1]==b[W-1] && res[W-1]!=a[W-1];
//    sub: a[W-1]!=b[W-1] && res[W-1]!=a[W-1].
//  - cy is the carry/borrow out of bit WIDTH-1, including effect of cin.
//  - Back-to-back: start in the DONE cycle is accepted; next done arrives N+1 cycles later.
//  - DIGIT==WIDTH: single RUN cycle, done in cycle 2.
// TESTING
//  1. W=8,D=1, add a=8'h5A b=8'h3C cin=0 -> busy cycles 1..8, done cycle 9, res=8'h96 cy=0 ovf=1.
//  2. W=8,D=1, sub a=8'h10 b=8'h20 cin=0 -> res=8'hF0 cy=1 ovf=0; sub a=8'h80 b=8'h01 cin=0
//     -> res=8'h7F cy=0 ovf=1; sub a=8'h05 b=8'h03 cin=1 -> res=8'h01 cy=0.
//  3. W=8,D=1, add a=8'hFF b=8'h00 cin=1 -> res=8'h00 cy=1 ovf=0 (full-width ripple).
//  4. start re-pulsed in RUN cycle 3 with other operands -> ignored, first result correct; start in
//     DONE cycle with a=1,b=1 add -> accepted, second done 9 cycles later, res=8'h02.
//  5. rst_n low in RUN cycle 4 -> next cycle busy=0 done=0 res=0 cy=0 ovf=0; no done pulse ever.
//  6. W=8,D=4 and W=8,D=8: random 1000 ops both modes vs {cy,res} = a+b+cin / a-b-cin
//     reference model; done at cycle 3 / 2 respectively.

Source files
------------

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: operands are consumed DIGIT bits per clock, LSB first,
// through a full-adder/full-subtractor chain whose carry/borrow is registered between digits.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cy,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mode_q, mode_d, c_q, c_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             cy_q, cy_d, ovf_q, ovf_d;

  logic [DIGIT-1:0]       dig;
  logic                   chain_c;
  logic [WIDTH+DIGIT-1:0] shifted;
  logic [WIDTH-1:0]       acc_next;
  logic                   last;

  // One digit of cells; chain_c carries between cells and leaves as the digit carry-out.
  always_comb begin
    logic ai, bi;
    chain_c = c_q;
    dig     = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      ai     = a_q[i];
      bi     = b_q[i];
      dig[i] = ai ^ bi ^ chain_c;
      if (mode_q) chain_c = (~(ai ^ bi) & chain_c) | (~ai & bi);
      else        chain_c = (ai & bi) | (bi & chain_c) | (chain_c & ai);
    end
  end

  // Widened concatenation keeps the shift legal when DIGIT == WIDTH.
  assign shifted  = {dig, acc_q};
  assign acc_next = shifted[WIDTH+DIGIT-1:DIGIT];
  assign last     = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    c_d     = c_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    res_d   = res_q;
    cy_d    = cy_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          c_d     = cin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        acc_d = acc_next;
        c_d   = chain_c;
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          state_d = StDone;
          res_d   = acc_next;
          cy_d    = chain_c;
          ovf_d   = (mode_q ? (a_msb_q != b_msb_q) : (a_msb_q == b_msb_q)) &&
                    (acc_next[WIDTH-1] != a_msb_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign res  = res_q;
  assign cy   = cy_q;
  assign ovf  = ovf_q;

endmodule
